reaction_sequencer: RTL and testbench
=====================================

REACTION_SEQUENCER -- requirements
Module: reaction_sequencer

Interface
REQ-001 Parameter MIN_DELAY_MS, default 1000, fixed part of the pre-stimulus wait in ms.
REQ-002 Parameter MAX_MS, default 9999, reaction timeout and display saturation value.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ms_tick  input  1  one-clk-wide enable pulse, once per millisecond.
REQ-006 go  input  1  one-clk pulse (debounced btnU): start or restart a round.
REQ-007 react  input  1  one-clk pulse (debounced btnS): player response.
REQ-008 clr_best  input  1  one-clk pulse (debounced btnD): clear best score.
REQ-009 rand  input  14  LFSR value, sampled only on round start.
REQ-010 number  output  14  binary value for the display, 0..MAX_MS.
REQ-011 mode  output  2  display mode: 0 idle/best, 1 running, 2 result, 3 foul.
REQ-012 led  output  16  stimulus LEDs.

Function
REQ-013 The FSM SHALL have states IDLE, ARMED, LIT, RESULT and FOUL.
REQ-014 IDLE: go -> ARMED; delay target latched as MIN_DELAY_MS + rand[10:0]; ms counter cleared; react ignored.
REQ-015 ARMED: counter increments on ms_tick; the tick on which counter equals target-1 -> LIT with counter cleared to 0.
REQ-016 ARMED: react -> FOUL next cycle; react SHALL take priority over a same-cycle ms_tick expiry.
REQ-017 LIT: led = 16'hFFFF; counter increments on ms_tick, saturating at MAX_MS.
REQ-018 LIT: react at cycle N -> RESULT at N+1; last_time = counter value at N, excluding any same-cycle ms_tick.
REQ-019 LIT: counter reaching MAX_MS with no react -> RESULT, last_time = MAX_MS, best not updated.
REQ-020 On entry to RESULT from react, best SHALL become min(best, last_time).
REQ-021 RESULT/FOUL: go -> ARMED (new round, new rand sample); react ignored.
REQ-022 go in any state other than IDLE/RESULT/FOUL SHALL be ignored.
REQ-023 clr_best SHALL set best to MAX_MS in IDLE, RESULT or FOUL, and be ignored in ARMED/LIT.
REQ-024 Outputs: IDLE number=best, mode=0; ARMED number=0, mode=1; LIT number=counter, mode=1; RESULT number=last_time, mode=2; FOUL number=0, mode=3.
REQ-025 led SHALL be 16'h0000 in all states except LIT; FOUL SHALL drive led = 16'hAAAA.
REQ-026 All outputs SHALL be registered; each state change is visible on the outputs 1 clk after the triggering input.
REQ-027 Counter arithmetic SHALL be 14-bit unsigned with no wrap-around past MAX_MS.

Reset
REQ-028 rst SHALL force IDLE, counter=0, last_time=0, best=MAX_MS, number=MAX_MS, mode=0, led=0.
REQ-029 rst asserted mid-round SHALL abort the round with no best update and take priority over all inputs.

Structure
REQ-030 Package reaction_pkg SHALL hold the state enum, the mode codes (MODE_IDLE..MODE_FOUL) and the LED pattern constants.
REQ-031 The ms counter SHALL be a sub-module rt_counter (clear, enable, saturation limit, 14-bit count).
REQ-032 No clock division inside the block; all timing comes from ms_tick.

Verification
REQ-033 rand=14'h0123 (rand[10:0]=291), go, tick every cycle -> LIT after exactly 1291 ticks; led=FFFF, mode=1.
REQ-034 In LIT, react after 250 ticks -> next clk mode=2, number=250; return to IDLE not possible without rst, best=250 shown after rst-free clr check.
REQ-035 react during ARMED at tick 500 -> FOUL, mode=3, number=0, led=AAAA; best unchanged.
REQ-036 LIT with no react -> RESULT at 9999 ticks, number=9999, best stays at its prior value (e.g. 250).
REQ-037 Rounds of 300 then 400 -> best=300; clr_best in RESULT -> best=9999; rst during LIT -> IDLE, number=9999, led=0.
REQ-038 react and ms_tick in the same cycle at counter=42 in LIT -> number=42.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game sequencer.
// Holds the FSM state encoding, display mode codes and LED patterns.
package reaction_pkg;

   localparam int CNT_W = 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_LIT,
      ST_RESULT,
      ST_FOUL
   } state_t;

   localparam logic [1:0] MODE_IDLE    = 2'd0;
   localparam logic [1:0] MODE_RUNNING = 2'd1;
   localparam logic [1:0] MODE_RESULT  = 2'd2;
   localparam logic [1:0] MODE_FOUL    = 2'd3;

   localparam logic [15:0] LED_OFF  = 16'h0000;
   localparam logic [15:0] LED_LIT  = 16'hFFFF;
   localparam logic [15:0] LED_FOUL = 16'hAAAA;

endpackage

// File: rtl/rt_counter.sv
// Millisecond counter: synchronous clear, enable-gated increment, saturates at limit.
// count_next is exported so the parent can register outputs without an extra cycle of lag.
module rt_counter #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next
);

   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (enable && (count < limit)) begin
         count_next = count + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: random pre-stimulus wait, reaction timing, best-score tracking.
// All outputs are registered from next-state values so every change shows one clock after its cause.
module reaction_sequencer
   import reaction_pkg::*;
#(
   parameter int MIN_DELAY_MS = 1000,
   parameter int MAX_MS       = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ms_tick,
   input  logic             go,
   input  logic             react,
   input  logic             clr_best,
   // LFSR sample; named rand_val because 'rand' is a reserved word
   input  logic [CNT_W-1:0] rand_val,
   output logic [CNT_W-1:0] number,
   output logic [1:0]       mode,
   output logic [15:0]      led,
   output state_t           dbg_state,
   output logic [CNT_W-1:0] dbg_best
);

   localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_DELAY_MS);
   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_MS);

   state_t           state, state_next;
   logic [CNT_W-1:0] target, target_next;
   logic [CNT_W-1:0] last_time, last_next;
   logic [CNT_W-1:0] best, best_next;
   logic [CNT_W-1:0] count, count_next;
   logic             cnt_clear, cnt_enable;
   logic [CNT_W-1:0] number_next;
   logic [1:0]       mode_next;
   logic [15:0]      led_next;
   logic             unused_rand_hi;

   assign unused_rand_hi = ^rand_val[13:11];

   rt_counter #(.W(CNT_W)) u_counter (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .enable     (cnt_enable),
      .limit      (MAX_VAL),
      .count      (count),
      .count_next (count_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         target    <= '0;
         last_time <= '0;
         best      <= MAX_VAL;
         number    <= MAX_VAL;
         mode      <= MODE_IDLE;
         led       <= LED_OFF;
      end else begin
         state     <= state_next;
         target    <= target_next;
         last_time <= last_next;
         best      <= best_next;
         number    <= number_next;
         mode      <= mode_next;
         led       <= led_next;
      end
   end

   always_comb begin
      state_next  = state;
      target_next = target;
      last_next   = last_time;
      best_next   = best;
      cnt_clear   = 1'b0;
      cnt_enable  = 1'b0;
      case (state)
         ST_ARMED: begin
            // react wins over a same-cycle expiry tick
            if (react) begin
               state_next = ST_FOUL;
            end else if (ms_tick) begin
               if (({1'b0, count} + 15'd1) >= {1'b0, target}) begin
                  state_next = ST_LIT;
                  cnt_clear  = 1'b1;
               end else begin
                  cnt_enable = 1'b1;
               end
            end
         end
         ST_LIT: begin
            if (react) begin
               state_next = ST_RESULT;
               last_next  = count;
               if (count < best) begin
                  best_next = count;
               end
            end else if (ms_tick) begin
               cnt_enable = 1'b1;
               if (({1'b0, count} + 15'd1) >= {1'b0, MAX_VAL}) begin
                  state_next = ST_RESULT;
                  last_next  = MAX_VAL;
               end
            end
         end
         default: begin
            if (clr_best) begin
               best_next = MAX_VAL;
            end
            if (go) begin
               state_next  = ST_ARMED;
               cnt_clear   = 1'b1;
               target_next = MIN_VAL + {3'b000, rand_val[10:0]};
            end
         end
      endcase
   end

   always_comb begin
      number_next = '0;
      mode_next   = MODE_IDLE;
      led_next    = LED_OFF;
      case (state_next)
         ST_IDLE: begin
            number_next = best_next;
         end
         ST_ARMED: begin
            mode_next = MODE_RUNNING;
         end
         ST_LIT: begin
            number_next = count_next;
            mode_next   = MODE_RUNNING;
            led_next    = LED_LIT;
         end
         ST_RESULT: begin
            number_next = last_next;
            mode_next   = MODE_RESULT;
         end
         ST_FOUL: begin
            mode_next = MODE_FOUL;
            led_next  = LED_FOUL;
         end
         default: begin
            number_next = '0;
         end
      endcase
   end

   assign dbg_state = state;
   assign dbg_best  = best;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: vector table, directed rounds, random stimulus
// checked every cycle against an elapsed-time model of the game.
module tb_reaction_sequencer;
   import reaction_pkg::*;

   localparam int MIN_MS = 1000;
   localparam int MAX_MS = 9999;

   logic        clk = 1'b0;
   logic        rst, ms_tick, go, react, clr_best;
   logic [13:0] rand_val;
   logic [13:0] number;
   logic [1:0]  mode;
   logic [15:0] led;
   state_t      dbg_state;
   logic [13:0] dbg_best;

   always #5 clk = ~clk;

   reaction_sequencer #(.MIN_DELAY_MS(MIN_MS), .MAX_MS(MAX_MS)) dut (
      .clk       (clk),
      .rst       (rst),
      .ms_tick   (ms_tick),
      .go        (go),
      .react     (react),
      .clr_best  (clr_best),
      .rand_val  (rand_val),
      .number    (number),
      .mode      (mode),
      .led       (led),
      .dbg_state (dbg_state),
      .dbg_best  (dbg_best)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: time since the round's go, versus the drawn wait.
   bit m_started;   // a round has begun since reset
   bit m_active;    // round still running (waiting or lit)
   bit m_foul;
   int m_ticks, m_wait, m_last, m_best;

   function automatic int exp_number();
      if (!m_started) return m_best;
      if (m_active)   return (m_ticks < m_wait) ? 0 : m_ticks - m_wait;
      if (m_foul)     return 0;
      return m_last;
   endfunction

   function automatic int exp_mode();
      if (!m_started) return 0;
      if (m_active)   return 1;
      if (m_foul)     return 3;
      return 2;
   endfunction

   function automatic int exp_led();
      if (m_started && m_active && m_ticks >= m_wait) return 32'hFFFF;
      if (m_started && !m_active && m_foul)           return 32'hAAAA;
      return 0;
   endfunction

   task automatic model_step(input bit r, input bit g, input bit rc, input bit c, input bit t,
                             input logic [13:0] rv);
      if (r) begin
         m_started = 0; m_active = 0; m_foul = 0;
         m_ticks = 0; m_last = 0; m_best = MAX_MS;
      end else if (m_active) begin
         if (m_ticks < m_wait) begin
            if (rc) begin
               m_active = 0; m_foul = 1;
            end else if (t) begin
               m_ticks++;
            end
         end else begin
            if (rc) begin
               m_last = m_ticks - m_wait;
               if (m_last < m_best) m_best = m_last;
               m_active = 0;
            end else if (t) begin
               m_ticks++;
               if (m_ticks - m_wait >= MAX_MS) begin
                  m_last = MAX_MS; m_active = 0;
               end
            end
         end
      end else begin
         if (c) m_best = MAX_MS;
         if (g) begin
            m_started = 1; m_active = 1; m_foul = 0;
            m_ticks = 0; m_wait = MIN_MS + int'(rv[10:0]);
         end
      end
   endtask

   task automatic step(input bit r, input bit g, input bit rc, input bit c, input bit t,
                       input logic [13:0] rv);
      rst = r; go = g; react = rc; clr_best = c; ms_tick = t; rand_val = rv;
      @(posedge clk);
      model_step(r, g, rc, c, t, rv);
      @(negedge clk);
      check("model_number", number, exp_number());
      check("model_mode", mode, exp_mode());
      check("model_led", led, exp_led());
      check("model_best", dbg_best, m_best);
   endtask

   task automatic run_ticks(input int n, input logic [13:0] rv);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, rv);
   endtask

   typedef struct {
      bit g; bit r; bit c; bit t;
      int e_num; int e_mode; int e_led;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [13:0] rv;
      rv = 14'h0123;

      // IDLE/ARMED/FOUL handshakes, one row per clock
      vecs[0] = '{g:0, r:1, c:0, t:0, e_num:9999, e_mode:0, e_led:0};
      vecs[1] = '{g:0, r:0, c:1, t:0, e_num:9999, e_mode:0, e_led:0};
      vecs[2] = '{g:0, r:0, c:0, t:1, e_num:9999, e_mode:0, e_led:0};
      vecs[3] = '{g:1, r:0, c:0, t:0, e_num:0,    e_mode:1, e_led:0};
      vecs[4] = '{g:1, r:0, c:0, t:1, e_num:0,    e_mode:1, e_led:0};
      vecs[5] = '{g:0, r:0, c:1, t:0, e_num:0,    e_mode:1, e_led:0};
      vecs[6] = '{g:0, r:1, c:0, t:1, e_num:0,    e_mode:3, e_led:32'hAAAA};
      vecs[7] = '{g:0, r:1, c:0, t:0, e_num:0,    e_mode:3, e_led:32'hAAAA};
      vecs[8] = '{g:0, r:0, c:0, t:1, e_num:0,    e_mode:3, e_led:32'hAAAA};
      vecs[9] = '{g:1, r:0, c:0, t:0, e_num:0,    e_mode:1, e_led:0};

      step(1, 0, 0, 0, 0, rv);
      step(1, 0, 0, 0, 0, rv);
      check("reset_number", number, 9999);
      check("reset_mode", mode, 0);
      check("reset_led", led, 0);
      check("reset_state", dbg_state, ST_IDLE);

      foreach (vecs[i]) begin
         step(0, vecs[i].g, vecs[i].r, vecs[i].c, vecs[i].t, rv);
         check($sformatf("vec%0d_number", i), number, vecs[i].e_num);
         check($sformatf("vec%0d_mode", i), mode, vecs[i].e_mode);
         check($sformatf("vec%0d_led", i), led, vecs[i].e_led);
      end

      // Wait of 1000 + 291 ticks before the stimulus lights
      run_ticks(1290, rv);
      check("armed_last_tick_led", led, 0);
      check("armed_last_tick_mode", mode, 1);
      run_ticks(1, rv);
      check("lit_led", led, 16'hFFFF);
      check("lit_mode", mode, 1);
      check("lit_number", number, 0);

      run_ticks(250, rv);
      check("lit_250_number", number, 250);
      step(0, 0, 1, 0, 0, rv);
      check("result_mode", mode, 2);
      check("result_number", number, 250);
      check("result_best", dbg_best, 250);
      step(0, 0, 1, 0, 0, rv);
      check("result_react_ignored", number, 250);

      // Timeout with no reaction
      step(0, 1, 0, 0, 0, rv);
      run_ticks(1291, rv);
      run_ticks(9998, rv);
      check("timeout_pre_mode", mode, 1);
      check("timeout_pre_number", number, 9998);
      run_ticks(1, rv);
      check("timeout_mode", mode, 2);
      check("timeout_number", number, 9999);
      check("timeout_best_kept", dbg_best, 250);

      // Early reaction is a foul
      step(0, 1, 0, 0, 0, rv);
      run_ticks(500, rv);
      step(0, 0, 1, 0, 0, rv);
      check("foul_mode", mode, 3);
      check("foul_number", number, 0);
      check("foul_led", led, 16'hAAAA);
      check("foul_best_kept", dbg_best, 250);
      check("foul_state", dbg_state, ST_FOUL);

      step(0, 0, 0, 1, 0, rv);
      check("clr_in_foul", dbg_best, 9999);

      // Rounds of 300 then 400 keep the better score
      step(0, 1, 0, 0, 0, rv);
      run_ticks(1291 + 300, rv);
      step(0, 0, 1, 0, 0, rv);
      check("round300_best", dbg_best, 300);
      step(0, 1, 0, 0, 0, rv);
      run_ticks(1291 + 400, rv);
      step(0, 0, 1, 0, 0, rv);
      check("round400_number", number, 400);
      check("round400_best", dbg_best, 300);
      step(0, 0, 0, 1, 0, rv);
      check("clr_in_result", dbg_best, 9999);
      check("clr_in_result_number", number, 400);

      // Reset mid-round
      step(0, 1, 0, 0, 0, rv);
      run_ticks(1291 + 100, rv);
      step(1, 0, 1, 0, 1, rv);
      check("rst_lit_mode", mode, 0);
      check("rst_lit_number", number, 9999);
      check("rst_lit_led", led, 0);
      check("rst_lit_best", dbg_best, 9999);

      // React and tick in the same cycle
      step(0, 1, 0, 0, 0, rv);
      run_ticks(1291 + 42, rv);
      step(0, 0, 1, 0, 1, rv);
      check("react_tick_number", number, 42);
      check("react_tick_mode", mode, 2);

      // Random play
      for (int i = 0; i < 15000; i++) begin
         bit r, g, rc, c, t;
         r  = ($urandom_range(0, 1999) == 0);
         g  = ($urandom_range(0, 99) < 3);
         rc = ($urandom_range(0, 99) < 1);
         c  = ($urandom_range(0, 99) < 1);
         t  = ($urandom_range(0, 9) < 7);
         step(r, g, rc, c, t, 14'($urandom_range(0, 16383)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
